// File: rtl/sa_wresp_router_pkg.sv
// Shared types and helpers for the slave-side write-response router.
// BRESP encodings, the response record, and master-index width derivation.
package sa_wresp_router_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } bresp_e;

    localparam int DEF_TRANS_MST_ID_W  = 5;
    localparam int DEF_TRANS_WR_RESP_W = 2;

    typedef struct packed {
        logic [DEF_TRANS_MST_ID_W-1:0]  id;
        logic [DEF_TRANS_WR_RESP_W-1:0] resp;
    } resp_info_t;

    // A single master still needs a one-bit index.
    function automatic int mst_id_width(input int mst_amt);
        return (mst_amt > 1) ? $clog2(mst_amt) : 1;
    endfunction

endpackage

// File: rtl/sa_wresp_ord_fifo.sv
// Master-order FIFO: holds the owner of each accepted AW in grant order.
// Head is read combinationally so the owner is known in the pop cycle.
module sa_wresp_ord_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           head,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/sa_wresp_router.sv
// Slave-side B-channel router: returns each slave response to the master that owns it.
// Optional macro SA_WRESP_ID_CHECK_EN adds a sticky id_err_o for BID/owner disagreement.
module sa_wresp_router
    import sa_wresp_router_pkg::*;
#(
    parameter int MST_AMT         = 2,
    parameter int OUTSTANDING_AMT = 8,
    parameter int TRANS_MST_ID_W  = 5,
    parameter int TRANS_WR_RESP_W = 2,
    parameter int MST_ID_W        = mst_id_width(MST_AMT)
) (
    input  logic                              ACLK_i,
    input  logic                              ARESET_i,
    input  logic [MST_ID_W-1:0]               aw_mst_id_i,
    input  logic                              aw_shift_en_i,
    output logic                              ord_full_o,
    output logic [$clog2(OUTSTANDING_AMT):0]  outstanding_o,
    input  logic [TRANS_MST_ID_W-1:0]         s_BID_i,
    input  logic [TRANS_WR_RESP_W-1:0]        s_BRESP_i,
    input  logic                              s_BVALID_i,
    output logic                              s_BREADY_o,
    output logic [TRANS_MST_ID_W-1:0]         dsp_BID_o,
    output logic [TRANS_WR_RESP_W-1:0]        dsp_BRESP_o,
    output logic [MST_AMT-1:0]                dsp_BVALID_o,
    input  logic [MST_AMT-1:0]                dsp_BREADY_i
`ifdef SA_WRESP_ID_CHECK_EN
    ,
    output logic                              id_err_o
`endif
);
    localparam int CNT_W = $clog2(OUTSTANDING_AMT) + 1;

    logic [MST_ID_W-1:0]        ord_head;
    logic                       ord_empty;
    logic                       ord_full;
    logic [CNT_W-1:0]           ord_count;
    logic                       out_valid_q;
    logic [MST_ID_W-1:0]        out_mst_q;
    logic [TRANS_MST_ID_W-1:0]  bid_q;
    logic [TRANS_WR_RESP_W-1:0] bresp_q;
    logic                       out_ready;
    logic                       s_hs;

    sa_wresp_ord_fifo #(
        .DEPTH (OUTSTANDING_AMT),
        .WIDTH (MST_ID_W)
    ) u_ord_fifo (
        .clk   (ACLK_i),
        .rst   (ARESET_i),
        .push  (aw_shift_en_i),
        .pop   (s_hs),
        .din   (aw_mst_id_i),
        .head  (ord_head),
        .empty (ord_empty),
        .full  (ord_full),
        .count (ord_count)
    );

    // BREADY uses only registered state and dispatcher readies, never s_BVALID_i.
    assign out_ready  = ~out_valid_q | dsp_BREADY_i[out_mst_q];
    assign s_BREADY_o = ~ord_empty & out_ready;
    assign s_hs       = s_BVALID_i & s_BREADY_o;

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            out_valid_q <= 1'b0;
            out_mst_q   <= '0;
            bid_q       <= '0;
            bresp_q     <= '0;
        end else if (s_hs) begin
            out_valid_q <= 1'b1;
            out_mst_q   <= ord_head;
            bid_q       <= s_BID_i;
            bresp_q     <= s_BRESP_i;
        end else if (dsp_BREADY_i[out_mst_q]) begin
            out_valid_q <= 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MST_AMT; gi++) begin : g_bvalid
            assign dsp_BVALID_o[gi] = out_valid_q & (out_mst_q == MST_ID_W'(gi));
        end
    endgenerate

    assign dsp_BID_o     = bid_q;
    assign dsp_BRESP_o   = bresp_q;
    assign ord_full_o    = ord_full;
    assign outstanding_o = ord_count + CNT_W'(out_valid_q);

`ifdef SA_WRESP_ID_CHECK_EN
    logic                id_err_q;
    logic [MST_ID_W-1:0] bid_mst;

    assign bid_mst = s_BID_i[TRANS_MST_ID_W-1 -: MST_ID_W];

    // Mismatch is only flagged; the response still follows the recorded owner.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) id_err_q <= 1'b0;
        else if (s_hs && (bid_mst != ord_head)) id_err_q <= 1'b1;
    end

    assign id_err_o = id_err_q;
`endif

    a_no_push_when_full: assert property (@(posedge ACLK_i) disable iff (ARESET_i)
        !(aw_shift_en_i && ord_full))
        else $warning("aw_shift_en_i while order FIFO full: push dropped");

endmodule

// File: tb/tb_sa_wresp_router.sv
// Randomized bench for sa_wresp_router against a queue-based reference model.
// Directed sequences cover ordering, full, backpressure, spurious BVALID and reset.
module tb_sa_wresp_router;
    import sa_wresp_router_pkg::*;

    localparam int MST_AMT = 2;
    localparam int DEPTH   = 8;
    localparam int IDW     = 5;
    localparam int RW      = 2;
    localparam int MW      = 1;
    localparam int CW      = 4;

    logic           clk = 1'b0;
    logic           ARESET_i = 1'b1;
    logic [MW-1:0]  aw_mst_id_i = '0;
    logic           aw_shift_en_i = 1'b0;
    logic           ord_full_o;
    logic [CW-1:0]  outstanding_o;
    logic [IDW-1:0] s_BID_i = '0;
    logic [RW-1:0]  s_BRESP_i = '0;
    logic           s_BVALID_i = 1'b0;
    logic           s_BREADY_o;
    logic [IDW-1:0] dsp_BID_o;
    logic [RW-1:0]  dsp_BRESP_o;
    logic [MST_AMT-1:0] dsp_BVALID_o;
    logic [MST_AMT-1:0] dsp_BREADY_i = '0;
`ifdef SA_WRESP_ID_CHECK_EN
    logic           id_err_o;
`endif

    always #5 clk = ~clk;

    sa_wresp_router #(
        .MST_AMT         (MST_AMT),
        .OUTSTANDING_AMT (DEPTH),
        .TRANS_MST_ID_W  (IDW),
        .TRANS_WR_RESP_W (RW)
    ) dut (
        .ACLK_i        (clk),
        .ARESET_i      (ARESET_i),
        .aw_mst_id_i   (aw_mst_id_i),
        .aw_shift_en_i (aw_shift_en_i),
        .ord_full_o    (ord_full_o),
        .outstanding_o (outstanding_o),
        .s_BID_i       (s_BID_i),
        .s_BRESP_i     (s_BRESP_i),
        .s_BVALID_i    (s_BVALID_i),
        .s_BREADY_o    (s_BREADY_o),
        .dsp_BID_o     (dsp_BID_o),
        .dsp_BRESP_o   (dsp_BRESP_o),
        .dsp_BVALID_o  (dsp_BVALID_o),
        .dsp_BREADY_i  (dsp_BREADY_i)
`ifdef SA_WRESP_ID_CHECK_EN
        ,
        .id_err_o      (id_err_o)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference model: owners waiting for a response, plus the one held response.
    int         ord_q[$];
    bit         hv;
    int         hm;
    resp_info_t held;
    bit         id_err_m;

    task automatic model_clear();
        ord_q.delete();
        hv = 1'b0;
        hm = 0;
        held = '0;
        id_err_m = 1'b0;
    endtask

    function automatic bit model_sready();
        return (ord_q.size() != 0) && (!hv || dsp_BREADY_i[hm]);
    endfunction

    task automatic model_advance();
        bit sr;
        bit full;
        int h;
        sr   = model_sready();
        full = (ord_q.size() == DEPTH);
        if (s_BVALID_i && sr) begin
            h = ord_q.pop_front();
            if (int'(s_BID_i[IDW-1]) != h) id_err_m = 1'b1;
            hv = 1'b1;
            hm = h;
            held.id = s_BID_i;
            held.resp = s_BRESP_i;
        end else if (hv && dsp_BREADY_i[hm]) begin
            hv = 1'b0;
        end
        if (aw_shift_en_i && !full) ord_q.push_back(int'(aw_mst_id_i));
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".full"},   32'(ord_full_o),    32'(ord_q.size() == DEPTH));
        check({tag, ".outst"},  32'(outstanding_o), 32'(ord_q.size() + int'(hv)));
        check({tag, ".sready"}, 32'(s_BREADY_o),    32'(model_sready()));
        check({tag, ".bvalid"}, 32'(dsp_BVALID_o),  hv ? (32'd1 << hm) : 32'd0);
        check({tag, ".bid"},    32'(dsp_BID_o),     32'(held.id));
        check({tag, ".bresp"},  32'(dsp_BRESP_o),   32'(held.resp));
`ifdef SA_WRESP_ID_CHECK_EN
        check({tag, ".iderr"},  32'(id_err_o),      32'(id_err_m));
`endif
    endtask

    task automatic drive(input string tag, input logic aw, input logic [MW-1:0] mst,
                         input logic bv, input logic [IDW-1:0] bid,
                         input logic [RW-1:0] resp, input logic [1:0] br);
        @(negedge clk);
        aw_shift_en_i = aw;
        aw_mst_id_i   = mst;
        s_BVALID_i    = bv;
        s_BID_i       = bid;
        s_BRESP_i     = resp;
        dsp_BREADY_i  = br;
        #1;
        compare_all(tag);
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        ARESET_i = 1'b1;
        aw_shift_en_i = 1'b0;
        aw_mst_id_i = '0;
        s_BVALID_i = 1'b0;
        s_BID_i = '0;
        s_BRESP_i = '0;
        dsp_BREADY_i = '0;
        #1;
        model_clear();
        compare_all(tag);
        @(negedge clk);
        ARESET_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        while ((ord_q.size() != 0 || hv) && budget < 200) begin
            drive(tag, 1'b0, 1'b0, 1'b1, 5'($urandom), 2'($urandom), 2'b11);
            tick();
            budget++;
        end
        if (budget >= 200) check({tag, ".timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [MW-1:0] mseq [3];
        logic [RW-1:0] rseq [3];
        logic [IDW-1:0] bid_r;
        int p_aw, p_bv, p_br;

        model_clear();
        do_reset("rst0");
        check("rst0.bvalid_zero", 32'(dsp_BVALID_o), 32'd0);
        check("rst0.outst_zero",  32'(outstanding_o), 32'd0);

        // Single transaction, latency and release.
        drive("s1.push", 1'b1, 1'b1, 1'b0, '0, '0, 2'b00); tick();
        drive("s1.resp", 1'b0, 1'b0, 1'b1, 5'h12, RESP_OKAY, 2'b00);
        check("s1.sready", 32'(s_BREADY_o), 32'd1);
        tick();
        drive("s1.held", 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        check("s1.bvalid", 32'(dsp_BVALID_o), 32'h2);
        check("s1.bid", 32'(dsp_BID_o), 32'h12);
        check("s1.outst", 32'(outstanding_o), 32'd1);
        tick();
        drive("s1.ack", 1'b0, 1'b0, 1'b0, '0, '0, 2'b10); tick();
        drive("s1.done", 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        check("s1.outst0", 32'(outstanding_o), 32'd0);
        tick();

        // Ordering with no bubbles.
        mseq[0] = 1'b0; mseq[1] = 1'b1; mseq[2] = 1'b0;
        rseq[0] = RESP_OKAY; rseq[1] = RESP_SLVERR; rseq[2] = RESP_EXOKAY;
        for (int i = 0; i < 3; i++) begin
            drive("s2.push", 1'b1, mseq[i], 1'b0, '0, '0, 2'b11); tick();
        end
        for (int i = 0; i < 4; i++) begin
            drive("s2.resp", 1'b0, 1'b0, i < 3, IDW'(i + 3), (i < 3) ? rseq[i % 3] : 2'b00, 2'b11);
            if (i > 0) begin
                check("s2.route", 32'(dsp_BVALID_o), 32'd1 << mseq[i-1]);
                check("s2.bresp", 32'(dsp_BRESP_o), 32'(rseq[i-1]));
            end
            if (i < 3) check("s2.sready", 32'(s_BREADY_o), 32'd1);
            tick();
        end

        // Fill, overflow attempt, then one pop.
        for (int i = 0; i < DEPTH; i++) begin
            drive("s3.fill", 1'b1, (i == 0) ? 1'b0 : 1'($urandom), 1'b0, '0, '0, 2'b00);
            tick();
        end
        drive("s3.ovf", 1'b1, 1'b1, 1'b0, '0, '0, 2'b00);
        check("s3.full", 32'(ord_full_o), 32'd1);
        check("s3.outst8", 32'(outstanding_o), 32'd8);
        tick();
        drive("s3.pop", 1'b0, 1'b0, 1'b1, 5'h07, RESP_SLVERR, 2'b00);
        check("s3.dropped", 32'(outstanding_o), 32'd8);
        check("s3.pop_rdy", 32'(s_BREADY_o), 32'd1);
        tick();
        drive("s3.after", 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        check("s3.notfull", 32'(ord_full_o), 32'd0);
        tick();

        // Backpressure on master 0; master 1 ready is ignored.
        for (int i = 0; i < 4; i++) begin
            drive("s4.bp", 1'b0, 1'b0, 1'b1, 5'($urandom), 2'($urandom), 2'b10);
            check("s4.bid", 32'(dsp_BID_o), 32'h07);
            check("s4.bresp", 32'(dsp_BRESP_o), 32'(RESP_SLVERR));
            check("s4.bvalid", 32'(dsp_BVALID_o), 32'h1);
            check("s4.stall", 32'(s_BREADY_o), 32'd0);
            tick();
        end
        drain("s4.drain");

        // Spurious BVALID while nothing is outstanding.
        for (int i = 0; i < 5; i++) begin
            drive("s5.spur", 1'b0, 1'b0, 1'b1, 5'h01, RESP_DECERR, 2'b11);
            check("s5.stall", 32'(s_BREADY_o), 32'd0);
            tick();
        end
        drive("s5.push", 1'b1, 1'b1, 1'b1, 5'h01, RESP_DECERR, 2'b11);
        check("s5.samecyc", 32'(s_BREADY_o), 32'd0);
        tick();
        drive("s5.rel", 1'b0, 1'b0, 1'b1, 5'h01, RESP_DECERR, 2'b11);
        check("s5.release", 32'(s_BREADY_o), 32'd1);
        tick();
        drain("s5.drain");

`ifdef SA_WRESP_ID_CHECK_EN
        do_reset("s6.rst");
        drive("s6.push", 1'b1, 1'b0, 1'b0, '0, '0, 2'b00); tick();
        drive("s6.resp", 1'b0, 1'b0, 1'b1, 5'h10, RESP_OKAY, 2'b00); tick();
        drive("s6.chk", 1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
        check("s6.iderr", 32'(id_err_o), 32'd1);
        check("s6.route", 32'(dsp_BVALID_o), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive("s6.sticky", 1'b0, 1'b0, 1'b0, '0, '0, 2'b11);
            check("s6.sticky", 32'(id_err_o), 32'd1);
            tick();
        end
        do_reset("s6.clr");
`endif

        // Randomized traffic in phases of differing pressure, with a mid-run reset.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset("rnd.rst");
            case ((c / 250) % 4)
                0:       begin p_aw = 50; p_bv = 50; p_br = 70; end
                1:       begin p_aw = 80; p_bv = 20; p_br = 50; end
                2:       begin p_aw = 20; p_bv = 80; p_br = 90; end
                default: begin p_aw = 60; p_bv = 60; p_br = 30; end
            endcase
            bid_r = 5'($urandom);
            drive("rnd",
                  ($urandom_range(99) < p_aw) && (ord_q.size() < DEPTH),
                  1'($urandom), $urandom_range(99) < p_bv, bid_r, 2'($urandom),
                  {$urandom_range(99) < p_br, $urandom_range(99) < p_br});
            tick();
        end
        drain("rnd.drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sa_wresp_router.md
Name: sa_wresp_router

Overview:
- Slave-side write-response router. One instance per slave port of the interconnect.
- Records which master owns each write accepted on that slave's AW channel, in the order the AW grants occur.
- Returns each B response from the slave to the owning master's dispatcher, in that same order.
- It is the B-channel counterpart of the master-side dispatcher's response merge: that logic collects responses per master; this block distributes them per slave.

Parameters:
- MST_AMT, 2, number of masters/dispatchers served.
- OUTSTANDING_AMT, 8, depth of the master-order FIFO (power of two, ≥2).
- TRANS_MST_ID_W, 5, BID width.
- TRANS_WR_RESP_W, 2, BRESP width.
- MST_ID_W, $clog2(MST_AMT), master index width (minimum 1).

Ports:
- ACLK_i  in  1  clock.
- ARESET_i  in  1  asynchronous, active-high reset.
- aw_mst_id_i  in  MST_ID_W  master granted on this slave's AW channel.
- aw_shift_en_i  in  1  AW handshake to slave completed this cycle; push aw_mst_id_i.
- ord_full_o  out  1  order FIFO full; AW arbiter must not grant.
- outstanding_o  out  $clog2(OUTSTANDING_AMT)+1  number of writes awaiting response.
- s_BID_i  in  TRANS_MST_ID_W  slave BID.
- s_BRESP_i  in  TRANS_WR_RESP_W  slave BRESP.
- s_BVALID_i  in  1  slave BVALID.
- s_BREADY_o  out  1  BREADY to slave.
- dsp_BID_o  out  TRANS_MST_ID_W  BID, broadcast to all dispatchers.
- dsp_BRESP_o  out  TRANS_WR_RESP_W  BRESP, broadcast to all dispatchers.
- dsp_BVALID_o  out  MST_AMT  one-hot BVALID per dispatcher.
- dsp_BREADY_i  in  MST_AMT  per-dispatcher BREADY.

Behaviour:
- Reset (async assert, sync release):
  - FIFO pointers and count go to 0; out_valid_q=0; out_mst_q=0; dsp_BID_o/dsp_BRESP_o=0.
  - Resulting outputs: ord_full_o=0, outstanding_o=0, s_BREADY_o=0, dsp_BVALID_o=0.
  - Reset mid-operation discards all outstanding entries and any held response.
- Push:
  - Occurs when aw_shift_en_i=1 and ord_full_o=0; writes aw_mst_id_i at the tail.
  - aw_shift_en_i while full is dropped. In simulation, an assertion fires.
- Output stage:
  - Single register: out_valid_q, out_mst_q, BID, BRESP.
  - out_ready = ~out_valid_q | dsp_BREADY_i[out_mst_q].
- s_BREADY_o = ~ord_empty & out_ready.
  - Both terms are registered state or dispatcher inputs; there is no combinational path from s_BVALID_i.
  - A response arriving while no write is outstanding stalls (BREADY=0).
- Slave handshake (s_BVALID_i & s_BREADY_o):
  - Pop the FIFO head into out_mst_q.
  - Capture s_BID_i and s_BRESP_i.
  - Set out_valid_q=1.
  - Latency: 1 cycle from slave handshake to dsp_BVALID_o.
- dsp_BVALID_o[i] = out_valid_q & (out_mst_q==i).
  - Output is held stable until dsp_BREADY_i[out_mst_q]=1.
  - dsp_BREADY_i of other masters is ignored.
- Master handshake with no new slave handshake clears out_valid_q. If both handshakes occur in the same cycle, the register reloads, giving back-to-back throughput of 1 response/cycle.
- Simultaneous push and pop: both take effect; count unchanged.
  - Push into an empty FIFO is not poppable in the same cycle, since ord_empty is registered.
  - When full, push is refused even if a pop occurs that cycle; ord_full_o depends on the count only.
- Pointers wrap modulo OUTSTANDING_AMT.
  - count ranges 0..OUTSTANDING_AMT.
  - ord_full_o = (count==OUTSTANDING_AMT).
  - outstanding_o = count + out_valid_q.

Optional Feature:
- Macro: SA_WRESP_ID_CHECK_EN.
- When defined:
  - Extra output id_err_o (1 bit).
  - Registered, sticky until reset.
  - Set when a slave handshake occurs and s_BID_i[TRANS_MST_ID_W-1 -: MST_ID_W] ≠ FIFO head.
  - The response is still routed to the FIFO head.
- When undefined: port absent, no compare logic; behaviour otherwise identical.

Decomposition:
- Shared package: MST_ID_W derivation, the BRESP encodings OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11, and a resp_info struct {id, resp}.
- One natural sub-module: sa_wresp_ord_fifo.
  - Synchronous FIFO with active-high async reset.
  - Outputs: head, empty, full, count.
- Output register and routing stay in the top module.

Test Plan:
- After reset, check all outputs are 0. Push mst 1, then drive BVALID with BID=5'h12, BRESP=2'b00 → s_BREADY_o=1. Next cycle dsp_BVALID_o=2'b10, dsp_BID_o=5'h12, outstanding_o=1. Then drive dsp_BREADY_i[1]=1 → outstanding_o=0.
- Order: push 0,1,0, then return 3 responses with BRESP 00,10,01 → delivered to masters 0,1,0 with matching BRESP. dsp_BREADY_i held 2'b11 → 1 response/cycle, no bubbles.
- Full: push 8 times without responses → ord_full_o=1, outstanding_o=8. A 9th push is dropped. One response popped → ord_full_o=0 the following cycle.
- Backpressure: dsp_BREADY_i[0]=0 for 4 cycles with a response held for mst 0 → dsp_BID_o/dsp_BRESP_o stable and s_BREADY_o=0. Setting dsp_BREADY_i[1]=1 has no effect.
- Spurious response: s_BVALID_i=1 with the FIFO empty → s_BREADY_o=0 indefinitely. A push then releases it 1 cycle later.
- With SA_WRESP_ID_CHECK_EN defined and MST_AMT=2: push mst 0, return BID=5'h10 (MSB=1) → id_err_o=1 next cycle and stays 1 until ARESET_i. The response is still sent to master 0.
